pipeline_sequencer: RTL

Central pipeline sequencer for the 5-stage CPU. Each cycle it takes the event flags from the hazard, branch and ALU logic and decides how the pipeline advances:

- PC write enable and next-PC source select
- hold and flush of the IF/ID, ID/EX and EX/MEM buffers
- halt draining, halted-state resume, and single-step
- overflow exception capture (EPC plus sticky flag)
- a saturating active-cycle counter

It replaces the scattered stall/flush/halt wiring between the control unit and the hazard unit.

---
 rtl/pipeline_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// Central pipeline sequencer for the 5-stage CPU.
// Turns hazard, branch, ALU and debug events into PC and pipeline-buffer
// controls. It also tracks the halt/drain/step state, captures overflow
// exceptions and counts active cycles.
module pipeline_sequencer #(
    parameter int ADDR_W       = 16,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_halt,
    input  logic              id_jump,
    input  logic              id_load_use,
    input  logic              ex_branch_taken,
    input  logic              ex_overflow,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              resume,
    input  logic              step,
    input  logic              exc_clear,
    output logic              pc_write,
    output logic [1:0]        pc_sel,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        state,
    output logic              halted,
    output logic [ADDR_W-1:0] epc,
    output logic              exc_flag,
    output logic [CNT_W-1:0]  cycle_count
);

    // The drain counter only ever holds values 0 .. DRAIN_CYCLES-1.
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    // Values driven on the next-PC mux select.
    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_TARGET = 2'd1;
    localparam logic [1:0] PC_SEL_VECTOR = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } seqState_e;

    seqState_e         state_q,  state_d;
    logic [DW-1:0]     drain_q,  drain_d;
    logic [ADDR_W-1:0] epc_q,    epc_d;
    logic              exc_q,    exc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // State, drain counter, exception capture and cycle counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            epc_q   <= '0;
            exc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            epc_q   <= epc_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Mealy pipeline controls, one event acting per cycle in RUN.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        epc_d        = epc_q;
        exc_d        = exc_q;
        pc_write     = 1'b0;
        pc_sel       = PC_SEL_SEQ;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        if (exc_clear) begin
            exc_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                pc_write = 1'b1;
                if (ex_overflow) begin
                    pc_sel       = PC_SEL_VECTOR;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    epc_d        = ex_pc;
                    exc_d        = 1'b1;
                end else if (ex_branch_taken) begin
                    pc_sel      = PC_SEL_TARGET;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (id_load_use) begin
                    pc_write    = 1'b0;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (id_jump) begin
                    pc_sel      = PC_SEL_TARGET;
                    if_id_flush = 1'b1;
                end else if (id_halt) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_d     = DRAIN_INIT;
                end
            end

            ST_DRAIN: begin
                if_id_flush = 1'b1;
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end

            ST_HALTED: begin
                if_id_flush = 1'b1;
                if (resume) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end

            ST_STEP: begin
                pc_write = 1'b1;
                state_d  = ST_DRAIN;
                drain_d  = DRAIN_INIT;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // While reset is held the pipeline is frozen and every buffer is flushed.
        if (!reset) begin
            pc_write     = 1'b0;
            pc_sel       = PC_SEL_SEQ;
            if_id_hold   = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end
    end

    // Saturating count of cycles spent outside HALTED.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_HALTED && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == ST_HALTED);
    assign epc         = epc_q;
    assign exc_flag    = exc_q;
    assign cycle_count = cnt_q;

endmodule
